tdm_deserializer: RTL and testbench

Receive end of the team's time-division serial link: takes a one-bit stream whose slots were selected by a counter-driven 8:1 multiplexer at the far end and rebuilds the parallel word. It is the sequential counterpart of the scanning multiplexer. It tracks slot position with an internal counter, demultiplexes each bit into a capture register, and hands completed frames to downstream logic over a valid/ready handshake. It sits between the link input pins and the parallel consumer, such as the decoder/display path.

---
 rtl/tdm_pkg.sv | 18 +
 rtl/tdm_slot_decoder.sv | 23 ++
 rtl/tdm_deserializer.sv | 144 ++++++++++++++
 tb/tb_tdm_deserializer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// tdm_pkg: shared types and constants for the TDM serial link receive path.
// Build option: define TDM_PARITY_EN to add a trailing even-parity slot per frame.
package tdm_pkg;

  typedef enum logic [0:0] {
    TDM_HUNT    = 1'b0,
    TDM_COLLECT = 1'b1
  } tdm_state_e;

  localparam int unsigned TDM_WIDTH_DEFAULT = 8;

`ifdef TDM_PARITY_EN
  localparam int unsigned TDM_PARITY_SLOTS = 1;
`else
  localparam int unsigned TDM_PARITY_SLOTS = 0;
`endif

endpackage

// File: rtl/tdm_slot_decoder.sv
// tdm_slot_decoder: binary slot index to one-hot capture write enable.
// Ports:
//   slot_addr_i - slot index to write
//   en_i        - write strobe; all enables low when 0
//   wr_en_c_o   - combinational one-hot write enable, N bits; an index of N or
//                 above (the parity slot) selects no capture bit
module tdm_slot_decoder #(
  parameter int unsigned N      = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic [ADDR_W-1:0] slot_addr_i,
  input  logic              en_i,
  output logic [N-1:0]      wr_en_c_o
);

  always_comb begin
    wr_en_c_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      wr_en_c_o[i] = en_i && (slot_addr_i == ADDR_W'(i));
    end
  end

endmodule

// File: rtl/tdm_deserializer.sv
// tdm_deserializer: rebuilds parallel words from a slot-multiplexed serial
// stream and hands complete frames downstream over valid/ready.
// Build option: TDM_PARITY_EN adds an even-parity slot after the data slots;
// without it parity_err is constant 0.
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset
//   en, frame, in_data- slot strobe, slot-0 marker, serial bit
//   out_data/out_valid/out_ready - registered output frame and handshake
//   slot_addr         - index of the next slot expected
//   sync_err, overrun, parity_err - one-cycle error pulses
module tdm_deserializer
  import tdm_pkg::*;
#(
  parameter int unsigned WIDTH  = TDM_WIDTH_DEFAULT,
  parameter int unsigned ADDR_W = $clog2(WIDTH + TDM_PARITY_SLOTS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              frame,
  input  logic              in_data,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] slot_addr,
  output logic              sync_err,
  output logic              overrun,
  output logic              parity_err
);

  localparam int unsigned SLOTS = WIDTH + TDM_PARITY_SLOTS;

  tdm_state_e        state_q;
  logic [ADDR_W-1:0] slot_addr_q;
  logic [WIDTH-1:0]  capture_q;
  logic [WIDTH-1:0]  capture_d;
  logic [WIDTH-1:0]  out_data_q;
  logic              out_valid_q;
  logic              sync_err_q;
  logic              overrun_q;
  logic              parity_err_q;

  logic [ADDR_W-1:0] dec_addr_c;
  logic              dec_en_c;
  logic [WIDTH-1:0]  wr_en_c;
  logic              handshake_c;
  logic              parity_ok_c;

  // A frame marker always targets slot 0; otherwise write the expected slot,
  // except at slot 0 of COLLECT where a missing marker discards the bit.
  always_comb begin
    dec_addr_c = frame ? '0 : slot_addr_q;
    dec_en_c   = en && (frame || ((state_q == TDM_COLLECT) && (slot_addr_q != '0)));
  end

  tdm_slot_decoder #(
    .N      (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_slot_decoder (
    .slot_addr_i (dec_addr_c),
    .en_i        (dec_en_c),
    .wr_en_c_o   (wr_en_c)
  );

  // Capture word including this cycle's bit, so completion sees the last slot.
  always_comb begin
    capture_d = capture_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (wr_en_c[i]) capture_d[i] = in_data;
    end
  end

  assign handshake_c = out_valid_q && out_ready;

`ifdef TDM_PARITY_EN
  // Completion happens on the parity slot; all data slots are already captured.
  assign parity_ok_c = (in_data == (^capture_q));
`else
  assign parity_ok_c = 1'b1;
`endif

  // Slot tracking FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= TDM_HUNT;
      slot_addr_q  <= '0;
      capture_q    <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      sync_err_q   <= 1'b0;
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      sync_err_q   <= 1'b0;
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
      capture_q    <= capture_d;
      if (handshake_c) out_valid_q <= 1'b0;

      if (en) begin
        case (state_q)
          TDM_HUNT: begin
            if (frame) begin
              state_q     <= TDM_COLLECT;
              slot_addr_q <= ADDR_W'(1);
            end
          end
          TDM_COLLECT: begin
            if (frame) begin
              // Restart: any partial frame is abandoned.
              if (slot_addr_q != '0) sync_err_q <= 1'b1;
              slot_addr_q <= ADDR_W'(1);
            end else if (slot_addr_q == '0) begin
              // Expected a frame marker after a completed frame.
              sync_err_q <= 1'b1;
              state_q    <= TDM_HUNT;
            end else if (slot_addr_q == ADDR_W'(SLOTS - 1)) begin
              slot_addr_q <= '0;
              if (!parity_ok_c) begin
                parity_err_q <= 1'b1;
              end else if (!out_valid_q || handshake_c) begin
                out_data_q  <= capture_d;
                out_valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              slot_addr_q <= slot_addr_q + ADDR_W'(1);
            end
          end
          default: state_q <= TDM_HUNT;
        endcase
      end
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign slot_addr  = slot_addr_q;
  assign sync_err   = sync_err_q;
  assign overrun    = overrun_q;
  assign parity_err = parity_err_q;

endmodule

// File: tb/tb_tdm_deserializer.sv
// tb_tdm_deserializer: directed scenarios for tdm_deserializer (WIDTH = 8).
module tb_tdm_deserializer;
  import tdm_pkg::*;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned ADDR_W = $clog2(WIDTH + TDM_PARITY_SLOTS);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic              frame;
  logic              in_data;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic              out_valid;
  logic [ADDR_W-1:0] slot_addr;
  logic              sync_err;
  logic              overrun;
  logic              parity_err;

  int checks = 0;
  int errors = 0;
  int n_sync = 0;
  int n_over = 0;
  int n_par  = 0;

  always #5 clk = ~clk;

  tdm_deserializer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .frame      (frame),
    .in_data    (in_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .slot_addr  (slot_addr),
    .sync_err   (sync_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  // One clock; observe #1 after the edge and tally error pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    if (sync_err === 1'b1)   n_sync++;
    if (overrun === 1'b1)    n_over++;
    if (parity_err === 1'b1) n_par++;
  endtask

  task automatic send_slot(input logic f, input logic d);
    en = 1'b1; frame = f; in_data = d;
    tick();
    en = 1'b0; frame = 1'b0; in_data = 1'b0;
  endtask

  // Full frame; with the parity build a parity slot follows (inverted if !par_good).
  task automatic send_frame(input logic [7:0] w, input logic par_good);
    for (int i = 0; i < 8; i++) send_slot(i == 0, w[i]);
`ifdef TDM_PARITY_EN
    send_slot(1'b0, (^w) ^ ~par_good);
`else
    if (!par_good) $display("note: parity request ignored in this build");
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; frame = 1'b0; in_data = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", out_data); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (slot_addr !== '0) begin errors++; $display("FAIL reset_addr got %0d want 0", slot_addr); end
    checks++; if ({sync_err, overrun, parity_err} !== 3'b000) begin
      errors++; $display("FAIL reset_pulses got %b want 000", {sync_err, overrun, parity_err});
    end
  endtask

  task automatic test_basic();
    logic [7:0] bits;
    bits = 8'b0100_1101;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_slot(i == 0, bits[i]);
      if (i == 6) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b want 0", out_valid); end
        checks++; if (slot_addr !== ADDR_W'(7)) begin errors++; $display("FAIL basic_addr7 got %0d want 7", slot_addr); end
      end
    end
`ifdef TDM_PARITY_EN
    send_slot(1'b0, ^bits);
`endif
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", out_valid); end
    checks++; if (out_data !== 8'h4D) begin errors++; $display("FAIL basic_data got %h want 4d", out_data); end
    checks++; if (slot_addr !== '0) begin errors++; $display("FAIL basic_addr_wrap got %0d want 0", slot_addr); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got %b want 0", out_valid); end
  endtask

  task automatic test_overrun();
    out_ready = 1'b0;
    send_frame(8'hA5, 1'b1);
    checks++; if (out_data !== 8'hA5 || out_valid !== 1'b1) begin
      errors++; $display("FAIL ovr_first got %h/%b want a5/1", out_data, out_valid);
    end
    n_over = 0;
    send_frame(8'h3C, 1'b1);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_pulse got %b want 1", overrun); end
    checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL ovr_data_kept got %h want a5", out_data); end
    tick();
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_pulse_len got %b want 0", overrun); end
    checks++; if (n_over != 1) begin errors++; $display("FAIL ovr_count got %0d want 1", n_over); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain got %b want 0", out_valid); end
  endtask

  task automatic test_sync();
    out_ready = 1'b1;
    n_sync = 0;
    send_slot(1'b1, 1'b0);
    for (int i = 1; i < 4; i++) send_slot(1'b0, 1'b0);
    checks++; if (slot_addr !== ADDR_W'(4)) begin errors++; $display("FAIL sync_addr4 got %0d want 4", slot_addr); end
    send_slot(1'b1, 1'b1);
    checks++; if (sync_err !== 1'b1) begin errors++; $display("FAIL sync_pulse got %b want 1", sync_err); end
    checks++; if (slot_addr !== ADDR_W'(1)) begin errors++; $display("FAIL sync_restart_addr got %0d want 1", slot_addr); end
    for (int i = 1; i < 8; i++) begin
      send_slot(1'b0, 1'b1);
      if (i < 7) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sync_partial_valid slot %0d got %b want 0", i, out_valid); end
      end
    end
`ifdef TDM_PARITY_EN
    send_slot(1'b0, 1'b0);
`endif
    checks++; if (out_data !== 8'hFF || out_valid !== 1'b1) begin
      errors++; $display("FAIL sync_data got %h/%b want ff/1", out_data, out_valid);
    end
    checks++; if (n_sync != 1) begin errors++; $display("FAIL sync_count got %0d want 1", n_sync); end
    tick();
  endtask

  task automatic test_sparse_en();
    logic [7:0] w;
    w = 8'h81;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_slot(i == 0, w[i]);
      if (i < 7 + int'(TDM_PARITY_SLOTS)) begin
        tick(); tick();
        checks++; if (slot_addr !== ADDR_W'(i + 1)) begin
          errors++; $display("FAIL sparse_addr slot %0d got %0d want %0d", i, slot_addr, i + 1);
        end
      end
    end
`ifdef TDM_PARITY_EN
    send_slot(1'b0, ^w);
`endif
    checks++; if (out_data !== 8'h81 || out_valid !== 1'b1) begin
      errors++; $display("FAIL sparse_data got %h/%b want 81/1", out_data, out_valid);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [7:0] w;
    w = 8'h0F;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send_slot(i == 0, w[i]);
    rst_n = 1'b0;
    send_slot(1'b0, 1'b1);
    rst_n = 1'b1;
    checks++; if (out_data !== 8'h00 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_out got %h/%b want 00/0", out_data, out_valid);
    end
    checks++; if (slot_addr !== '0) begin errors++; $display("FAIL rstmid_addr got %0d want 0", slot_addr); end
    // Still hunting: an unmarked slot must not start a frame.
    send_slot(1'b0, 1'b1);
    checks++; if (slot_addr !== '0 || sync_err !== 1'b0) begin
      errors++; $display("FAIL rstmid_hunt got %0d/%b want 0/0", slot_addr, sync_err);
    end
    send_frame(w, 1'b1);
    checks++; if (out_data !== 8'h0F || out_valid !== 1'b1) begin
      errors++; $display("FAIL rstmid_data got %h/%b want 0f/1", out_data, out_valid);
    end
    tick();
  endtask

  task automatic test_missing_frame();
    out_ready = 1'b1;
    n_sync = 0;
    send_slot(1'b0, 1'b1);
    checks++; if (sync_err !== 1'b1) begin errors++; $display("FAIL miss_pulse got %b want 1", sync_err); end
    send_slot(1'b0, 1'b1);
    checks++; if (sync_err !== 1'b0 || slot_addr !== '0) begin
      errors++; $display("FAIL miss_hunt got %b/%0d want 0/0", sync_err, slot_addr);
    end
    send_frame(8'h5A, 1'b1);
    checks++; if (out_data !== 8'h5A || out_valid !== 1'b1) begin
      errors++; $display("FAIL miss_data got %h/%b want 5a/1", out_data, out_valid);
    end
    checks++; if (n_sync != 1) begin errors++; $display("FAIL miss_count got %0d want 1", n_sync); end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    n_over = 0;
    send_frame(8'hC3, 1'b1);
    checks++; if (out_data !== 8'hC3 || out_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_first got %h/%b want c3/1", out_data, out_valid);
    end
    send_frame(8'h3A, 1'b1);
    checks++; if (out_data !== 8'h3A || out_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_second got %h/%b want 3a/1", out_data, out_valid);
    end
    checks++; if (n_over != 0) begin errors++; $display("FAIL b2b_overrun got %0d want 0", n_over); end
    tick();
  endtask

`ifdef TDM_PARITY_EN
  task automatic test_parity();
    out_ready = 1'b0;
    n_par = 0;
    n_over = 0;
    send_frame(8'h07, 1'b1);
    checks++; if (out_data !== 8'h07 || out_valid !== 1'b1) begin
      errors++; $display("FAIL par_good got %h/%b want 07/1", out_data, out_valid);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    send_frame(8'h07, 1'b0);
    checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL par_pulse got %b want 1", parity_err); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL par_drop_valid got %b want 0", out_valid); end
    checks++; if (n_par != 1 || n_over != 0) begin
      errors++; $display("FAIL par_counts got %0d/%0d want 1/0", n_par, n_over);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_sync();
    test_sparse_en();
    test_reset_mid();
    test_missing_frame();
    test_back_to_back();
`ifdef TDM_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
